// File: rtl/fir_pkg.sv
// Shared widths, state encoding and flush length for the FIR feeder.
// FIR_FEEDER_ZERO_FILL_EN adds the FLUSH state.
package fir_pkg;

  localparam int DEF_X_N_SIZE     = 8;
  localparam int DEF_TAP_SIZE     = 6;
  localparam int DEF_NBR_OF_TAPS  = 2;
  localparam int DEF_FIFO_DEPTH   = 8;
  localparam int DEF_SETUP_CYCLES = 4;

  localparam logic [2:0] ST_WAIT_SETUP = 3'd0;
  localparam logic [2:0] ST_IDLE       = 3'd1;
  localparam logic [2:0] ST_CFG_LEAD   = 3'd2;
  localparam logic [2:0] ST_CFG_SHIFT  = 3'd3;
  localparam logic [2:0] ST_GAP        = 3'd4;
  localparam logic [2:0] ST_STREAM     = 3'd5;
`ifdef FIR_FEEDER_ZERO_FILL_EN
  localparam logic [2:0] ST_FLUSH      = 3'd6;
`endif

  typedef enum logic [2:0] {
    S_WAIT_SETUP = ST_WAIT_SETUP,
    S_IDLE       = ST_IDLE,
    S_CFG_LEAD   = ST_CFG_LEAD,
    S_CFG_SHIFT  = ST_CFG_SHIFT,
    S_GAP        = ST_GAP,
`ifdef FIR_FEEDER_ZERO_FILL_EN
    S_STREAM     = ST_STREAM,
    S_FLUSH      = ST_FLUSH
`else
    S_STREAM     = ST_STREAM
`endif
  } state_t;

  // Zeros needed to push the last real sample through the delay line
  function automatic int flush_len(input int taps);
    return 2 * taps - 1;
  endfunction

endpackage

// File: rtl/fir_feeder_fifo.sv
// Sample FIFO for the FIR feeder: pointer based, registered count.
// Push while full and pop while empty are ignored.
module fir_feeder_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/fir_feeder.sv
// Input-side driver for the 2-tap adaptive FIR: coefficient upload + sample stream.
// Define FIR_FEEDER_ZERO_FILL_EN to zero-fill the FIR delay line when the stream runs dry.
module fir_feeder
  import fir_pkg::*;
#(
  parameter int X_N_SIZE     = DEF_X_N_SIZE,
  parameter int TAP_SIZE     = DEF_TAP_SIZE,
  parameter int NBR_OF_TAPS  = DEF_NBR_OF_TAPS,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           coef_wr,
  input  logic [$clog2(NBR_OF_TAPS)-1:0] coef_addr,
  input  logic [TAP_SIZE-1:0]            coef_data,
  input  logic                           load_req,
  input  logic                           s_wr_valid,
  input  logic [X_N_SIZE-1:0]            s_wr_data,
  output logic                           s_wr_ready,
  output logic [X_N_SIZE-1:0]            x_n,
  output logic                           s_set_coeffs,
  output logic                           s_axis_fir_tvalid,
  output logic                           busy
);

  localparam int AW   = $clog2(NBR_OF_TAPS);
  localparam int FW   = $clog2(FIFO_DEPTH) + 1;
  localparam int CMAX = SETUP_CYCLES + 2 * NBR_OF_TAPS;
  localparam int CW   = $clog2(CMAX + 1);
`ifdef FIR_FEEDER_ZERO_FILL_EN
  localparam int FLEN = flush_len(NBR_OF_TAPS);
`endif

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic                  r_load_pending;
  logic [TAP_SIZE-1:0]   r_coef [NBR_OF_TAPS];
  logic [X_N_SIZE-1:0]   r_x_n;
  logic                  r_set;
  logic                  r_tvalid;

  logic                  w_push;
  logic                  w_pop;
  logic [X_N_SIZE-1:0]   w_head;
  logic [FW-1:0]         w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_cfg;
  logic                  w_coef_we;
  logic                  w_load_clr;
  logic [X_N_SIZE-1:0]   w_lead_coef;
  logic [X_N_SIZE-1:0]   w_shift_coef;

  fir_feeder_fifo #(
    .WIDTH (X_N_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (s_wr_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign s_wr_ready = (w_count < FW'(FIFO_DEPTH));
  assign w_push     = s_wr_valid && !w_full;

  assign w_cfg      = (r_state == S_CFG_LEAD) || (r_state == S_CFG_SHIFT);
  assign w_coef_we  = coef_wr && !w_cfg;
  assign w_load_clr = (r_state == S_CFG_SHIFT) &&
                      (r_cnt == CW'(NBR_OF_TAPS - 1));

  assign w_pop = !w_empty &&
                 (((r_state == S_IDLE) && !r_load_pending && !load_req) ||
                  ((r_state == S_STREAM) && !r_load_pending));

  assign w_lead_coef = X_N_SIZE'($signed(r_coef[NBR_OF_TAPS-1]));

  // Highest tap leaves first: shift step k carries coef[N-1-k]
  always_comb begin
    w_shift_coef = w_lead_coef;
    for (int i = 0; i < NBR_OF_TAPS; i++) begin
      if (r_cnt == CW'(NBR_OF_TAPS - 1 - i))
        w_shift_coef = X_N_SIZE'($signed(r_coef[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NBR_OF_TAPS; i++) r_coef[i] <= '0;
    end else if (w_coef_we) begin
      for (int i = 0; i < NBR_OF_TAPS; i++) begin
        if (coef_addr == AW'(i)) r_coef[i] <= coef_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)           r_load_pending <= 1'b0;
    else if (w_load_clr) r_load_pending <= 1'b0;
    else if (load_req)   r_load_pending <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_WAIT_SETUP;
      r_cnt    <= '0;
      r_x_n    <= '0;
      r_set    <= 1'b0;
      r_tvalid <= 1'b0;
    end else begin
      r_x_n    <= '0;
      r_set    <= 1'b0;
      r_tvalid <= 1'b0;
      case (r_state)
        S_WAIT_SETUP: begin
          if (r_cnt == CW'(SETUP_CYCLES - 1)) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_IDLE: begin
          if (r_load_pending || load_req) begin
            r_state <= S_CFG_LEAD;
          end else if (!w_empty) begin
            r_state  <= S_STREAM;
            r_x_n    <= w_head;
            r_tvalid <= 1'b1;
          end
        end
        S_CFG_LEAD: begin
          r_set   <= 1'b1;
          r_x_n   <= w_lead_coef;
          r_cnt   <= '0;
          r_state <= S_CFG_SHIFT;
        end
        S_CFG_SHIFT: begin
          r_set <= 1'b1;
          r_x_n <= w_shift_coef;
          if (w_load_clr) begin
            r_state <= S_GAP;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (r_load_pending)  r_state <= S_CFG_LEAD;
          else if (!w_empty)   r_state <= S_STREAM;
          else                 r_state <= S_IDLE;
        end
        S_STREAM: begin
          if (r_load_pending) begin
            r_state <= S_GAP;
          end else if (!w_empty) begin
            r_x_n    <= w_head;
            r_tvalid <= 1'b1;
          end else begin
`ifdef FIR_FEEDER_ZERO_FILL_EN
            r_tvalid <= 1'b1;
            r_cnt    <= '0;
            if (FLEN < 2) r_state <= S_IDLE;
            else          r_state <= S_FLUSH;
`else
            r_state <= S_IDLE;
`endif
          end
        end
`ifdef FIR_FEEDER_ZERO_FILL_EN
        S_FLUSH: begin
          r_tvalid <= 1'b1;
          if (r_cnt == CW'(FLEN - 2)) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign x_n               = r_x_n;
  assign s_set_coeffs      = r_set;
  assign s_axis_fir_tvalid = r_tvalid;
  assign busy              = (r_state != S_IDLE);

endmodule

// File: tb/tb_fir_feeder.sv
// Self-checking bench for fir_feeder: queue/plan reference model plus directed pins.
// Honours FIR_FEEDER_ZERO_FILL_EN for the zero-fill tail.
module tb_fir_feeder;

  localparam int XW    = 8;
  localparam int TW    = 6;
  localparam int NT    = 2;
  localparam int DEPTH = 8;
  localparam int SETUP = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          coef_wr;
  logic [0:0]    coef_addr;
  logic [TW-1:0] coef_data;
  logic          load_req;
  logic          s_wr_valid;
  logic [XW-1:0] s_wr_data;
  logic          s_wr_ready;
  logic [XW-1:0] x_n;
  logic          s_set_coeffs;
  logic          s_axis_fir_tvalid;
  logic          busy;

  fir_feeder #(
    .X_N_SIZE     (XW),
    .TAP_SIZE     (TW),
    .NBR_OF_TAPS  (NT),
    .FIFO_DEPTH   (DEPTH),
    .SETUP_CYCLES (SETUP)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .coef_wr           (coef_wr),
    .coef_addr         (coef_addr),
    .coef_data         (coef_data),
    .load_req          (load_req),
    .s_wr_valid        (s_wr_valid),
    .s_wr_data         (s_wr_data),
    .s_wr_ready        (s_wr_ready),
    .x_n               (x_n),
    .s_set_coeffs      (s_set_coeffs),
    .s_axis_fir_tvalid (s_axis_fir_tvalid),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: a sample queue, a frozen coefficient snapshot and a
  // per-cycle plan of strobe outputs that an upload or flush commits to.
  typedef enum int {M_SETUP, M_READY, M_PLAN, M_GAPD, M_STREAM} mode_t;
  typedef struct {
    bit            set;
    bit            tv;
    logic [XW-1:0] x;
  } item_t;

  mode_t         mode;
  mode_t         plan_after;
  item_t         plan[$];
  logic [XW-1:0] q[$];
  logic [TW-1:0] mcoef[NT];
  bit            mlp;
  int            msetup;
  bit            model_ok = 0;
  logic [XW-1:0] exp_x;
  bit            exp_set;
  bit            exp_tv;

  function automatic logic [XW-1:0] sext(input logic [TW-1:0] c);
    int v;
    v = int'(c);
    if (v >= (1 << (TW - 1))) v -= (1 << TW);
    return XW'(v);
  endfunction

  task automatic start_upload();
    item_t it;
    plan.delete();
    it.set = 1;
    it.tv  = 0;
    it.x   = sext(mcoef[NT-1]);
    plan.push_back(it);
    for (int k = NT - 1; k >= 0; k--) begin
      it.x = sext(mcoef[k]);
      plan.push_back(it);
    end
    plan_after = M_GAPD;
    mode       = M_PLAN;
  endtask

  always @(posedge clk) begin : model_p
    bit    full;
    bit    wr_ok;
    bit    clr;
    item_t it;
    if (reset) begin
      mode     = M_SETUP;
      msetup   = SETUP;
      plan.delete();
      q.delete();
      for (int i = 0; i < NT; i++) mcoef[i] = '0;
      mlp      = 0;
      exp_x    = '0;
      exp_set  = 0;
      exp_tv   = 0;
      model_ok = 1;
    end else if (model_ok) begin
      full  = (q.size() >= DEPTH);
      wr_ok = coef_wr && !(mode == M_PLAN && plan.size() > 0 && plan[0].set);
      if (wr_ok) mcoef[coef_addr] = coef_data;
      clr     = 0;
      exp_x   = '0;
      exp_set = 0;
      exp_tv  = 0;
      case (mode)
        M_SETUP: begin
          msetup--;
          if (msetup == 0) mode = M_READY;
        end
        M_READY: begin
          if (mlp || load_req) start_upload();
          else if (q.size() > 0) begin
            exp_x  = q.pop_front();
            exp_tv = 1;
            mode   = M_STREAM;
          end
        end
        M_PLAN: begin
          it      = plan.pop_front();
          exp_x   = it.x;
          exp_set = it.set;
          exp_tv  = it.tv;
          if (plan.size() == 0) begin
            if (it.set) clr = 1;
            mode = plan_after;
          end
        end
        M_GAPD: begin
          if (mlp) start_upload();
          else if (q.size() > 0) mode = M_STREAM;
          else mode = M_READY;
        end
        M_STREAM: begin
          if (mlp) mode = M_GAPD;
          else if (q.size() > 0) begin
            exp_x  = q.pop_front();
            exp_tv = 1;
          end else begin
`ifdef FIR_FEEDER_ZERO_FILL_EN
            exp_tv = 1;
            plan.delete();
            it.set = 0;
            it.tv  = 1;
            it.x   = '0;
            for (int k = 0; k < 2 * NT - 2; k++) plan.push_back(it);
            plan_after = M_READY;
            mode = (plan.size() > 0) ? M_PLAN : M_READY;
`else
            mode = M_READY;
`endif
          end
        end
        default: mode = M_READY;
      endcase
      mlp = clr ? 1'b0 : (mlp | load_req);
      if (s_wr_valid && !full) q.push_back(s_wr_data);
    end
  end

  bit prev_set = 0;
  bit prev_tv  = 0;

  always @(negedge clk) begin
    if (model_ok) begin
      chk("x_n", int'(x_n), int'(exp_x));
      chk("s_set_coeffs", int'(s_set_coeffs), int'(exp_set));
      chk("tvalid", int'(s_axis_fir_tvalid), int'(exp_tv));
      chk("busy", int'(busy), int'(mode != M_READY));
      chk("s_wr_ready", int'(s_wr_ready), int'(q.size() < DEPTH));
      chk("strobe_overlap", int'(s_set_coeffs && s_axis_fir_tvalid), 0);
      chk("strobe_sep", int'((prev_set && s_axis_fir_tvalid) ||
                             (prev_tv && s_set_coeffs)), 0);
      prev_set = s_set_coeffs;
      prev_tv  = s_axis_fir_tvalid;
    end
  end

  logic [XW-1:0] got[$];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic tick_rec();
    @(negedge clk);
    if (s_axis_fir_tvalid) got.push_back(x_n);
  endtask

  initial begin
    int p;
    reset      = 1;
    coef_wr    = 0;
    coef_addr  = '0;
    coef_data  = '0;
    load_req   = 0;
    s_wr_valid = 0;
    s_wr_data  = '0;
    repeat (3) tick();

    // reset and setup hold-off
    reset = 0;
    chk("pin_rst_busy", int'(busy), 1);
    chk("pin_rst_x", int'(x_n), 0);
    for (int i = 1; i < SETUP; i++) begin
      tick();
      chk("pin_setup_busy", int'(busy), 1);
    end
    tick();
    chk("pin_idle_busy", int'(busy), 0);
    chk("pin_idle_strobes", int'(s_set_coeffs | s_axis_fir_tvalid), 0);

    // coefficient upload: coef[0]=3, coef[1]=-2
    coef_wr = 1; coef_addr = 1'b0; coef_data = 6'd3;
    tick();
    coef_addr = 1'b1; coef_data = 6'h3E;
    tick();
    coef_wr = 0; load_req = 1;
    tick();
    load_req = 0;
    chk("pin_cfg_pre", int'(s_set_coeffs), 0);
    tick();
    chk("pin_cfg0_set", int'(s_set_coeffs), 1);
    chk("pin_cfg0_x", int'(x_n), 8'hFE);
    tick();
    chk("pin_cfg1_set", int'(s_set_coeffs), 1);
    chk("pin_cfg1_x", int'(x_n), 8'hFE);
    tick();
    chk("pin_cfg2_set", int'(s_set_coeffs), 1);
    chk("pin_cfg2_x", int'(x_n), 8'h03);
    tick();
    chk("pin_gap", int'(s_set_coeffs | s_axis_fir_tvalid), 0);

    // stream 5, 7, 9
    s_wr_valid = 1; s_wr_data = 8'd5;
    tick();
    s_wr_data = 8'd7;
    tick();
    chk("pin_s0", int'(x_n), 5);
    chk("pin_s0_tv", int'(s_axis_fir_tvalid), 1);
    s_wr_data = 8'd9;
    tick();
    chk("pin_s1", int'(x_n), 7);
    s_wr_valid = 0;
    tick();
    chk("pin_s2", int'(x_n), 9);
    tick();
    chk("pin_s_end_tv", int'(s_axis_fir_tvalid), 0);
    chk("pin_s_end_x", int'(x_n), 0);

    // fill during setup + upload, 9th push dropped
    reset = 1;
    tick();
    reset = 0; load_req = 1; s_wr_valid = 1; s_wr_data = 8'd11;
    tick();
    load_req = 0;
    for (int i = 12; i <= 18; i++) begin
      s_wr_data = XW'(i);
      tick();
    end
    chk("pin_full_ready", int'(s_wr_ready), 0);
    s_wr_data = 8'd19;
    tick();
    chk("pin_full_ready2", int'(s_wr_ready), 0);
    s_wr_valid = 0;
    got.delete();
    repeat (30) tick_rec();
    chk("pin_fill_count", got.size(), 8);
    for (int i = 0; i < got.size() && i < 8; i++)
      chk("pin_fill_order", int'(got[i]), 11 + i);

    // upload request mid-stream with samples queued
    got.delete();
    load_req = 1; s_wr_valid = 1; s_wr_data = 8'd21;
    tick_rec();
    load_req = 0;
    for (int i = 22; i <= 26; i++) begin
      s_wr_data = XW'(i);
      tick_rec();
    end
    s_wr_valid = 0; load_req = 1;
    tick_rec();
    load_req = 0;
    repeat (40) tick_rec();
    chk("pin_mid_count", got.size(), 6);
    for (int i = 0; i < got.size() && i < 6; i++)
      chk("pin_mid_order", int'(got[i]), 21 + i);

`ifdef FIR_FEEDER_ZERO_FILL_EN
    s_wr_valid = 1; s_wr_data = 8'd1;
    tick();
    s_wr_valid = 0;
    tick();
    chk("pin_zf_x0", int'(x_n), 1);
    chk("pin_zf_tv0", int'(s_axis_fir_tvalid), 1);
    for (int i = 0; i < 2 * NT - 1; i++) begin
      tick();
      chk("pin_zf_x", int'(x_n), 0);
      chk("pin_zf_tv", int'(s_axis_fir_tvalid), 1);
    end
    tick();
    chk("pin_zf_end_tv", int'(s_axis_fir_tvalid), 0);
    chk("pin_zf_end_busy", int'(busy), 0);
`endif

    // randomized traffic against the model
    p = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 400 == 0) p = $urandom_range(5, 95);
      reset      = ($urandom_range(0, 999) == 0);
      s_wr_valid = ($urandom_range(0, 99) < p);
      s_wr_data  = XW'($urandom);
      coef_wr    = ($urandom_range(0, 9) == 0);
      coef_addr  = 1'($urandom);
      coef_data  = TW'($urandom);
      load_req   = ($urandom_range(0, 39) == 0);
      tick();
    end
    reset = 0; s_wr_valid = 0; coef_wr = 0; load_req = 0;
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_feeder.md
# fir_feeder

Upstream driver for the team's 2-tap adaptive FIR. It owns the FIR's input side, taking coefficients and samples from a simple host-side write interface. It waits out the FIR's post-reset setup window, then serialises the coefficient bank onto `x_n` under `s_set_coeffs`. It streams queued samples onto `x_n` under `s_axis_fir_tvalid`, never asserting both strobes together.

## Interface
Parameters:
- `X_N_SIZE`, 8, sample/coefficient bus width
- `TAP_SIZE`, 6, coefficient width; `TAP_SIZE <= X_N_SIZE`
- `NBR_OF_TAPS`, 2, coefficient bank depth
- `FIFO_DEPTH`, 8, sample FIFO entries, power of two
- `SETUP_CYCLES`, 4, cycles held off after reset

Ports:
- `clk` in 1: clock
- `reset` in 1: reset, synchronous, active-high; clock clk
- `coef_wr` in 1: write strobe into the coefficient bank
- `coef_addr` in `$clog2(NBR_OF_TAPS)`: tap index
- `coef_data` in `TAP_SIZE`: signed coefficient
- `load_req` in 1: single-cycle pulse requesting a bank upload to the FIR
- `s_wr_valid` in 1: sample push
- `s_wr_data` in `X_N_SIZE`: signed sample
- `s_wr_ready` out 1: high when the FIFO is not full
- `x_n` out `X_N_SIZE`: registered data to the FIR
- `s_set_coeffs` out 1: registered coefficient-shift strobe
- `s_axis_fir_tvalid` out 1: registered sample-valid strobe
- `busy` out 1: high in every state except IDLE

## Operation
- States: WAIT_SETUP, IDLE, CFG_LEAD, CFG_SHIFT, GAP, STREAM, plus FLUSH when the macro is defined.
- Reset:
  - state goes to WAIT_SETUP; counter, `x_n`, `s_set_coeffs`, `s_axis_fir_tvalid` go to 0; `busy` is 1.
  - FIFO is emptied and the coefficient bank is zeroed. `load_pending` is cleared.
  - Reset mid-operation aborts any upload or stream, with no partial recovery.
- WAIT_SETUP: counts `SETUP_CYCLES` cycles, then moves to IDLE. `coef_wr` and pushes are accepted; `load_req` is latched into `load_pending`.
- IDLE:
  - `load_pending` (or `load_req`) takes priority and moves to CFG_LEAD.
  - Otherwise, a non-empty FIFO moves to STREAM and pops the head at the same edge.
- CFG_LEAD (1 cycle): `s_set_coeffs`=1, `x_n`=sext(`coef[N-1]`). This is the FIR's state-entry slot.
- CFG_SHIFT (`NBR_OF_TAPS` cycles):
  - `s_set_coeffs`=1; `x_n` = sext(`coef[N-1]`), then `coef[N-2]` … `coef[0]`. Highest index goes first because the FIR shifts toward higher indices.
  - On exit, `load_pending` clears and the state moves to GAP.
- GAP (1 cycle): both strobes 0, `x_n`=0. Moves to STREAM if the FIFO is non-empty, otherwise IDLE.
- STREAM:
  - Each cycle with the FIFO non-empty: `x_n`=head, `tvalid`=1, pop.
  - A `load_pending` observed in STREAM ends the stream: `tvalid`=0 next cycle, then GAP, then CFG_LEAD. Unsent samples stay queued.
  - When the FIFO is empty: `tvalid`=0, `x_n`=0, go to IDLE (or FLUSH).
- `coef_wr` during CFG_LEAD/CFG_SHIFT is dropped. It is accepted in all other states.
- Push while full is dropped, since `s_wr_ready`=0. Push and pop in the same cycle are both honoured.
- `s_wr_ready` = !full, derived from the registered count. There is no same-cycle bypass.

## Timing
- Push at edge t into an empty FIFO while IDLE gives `x_n`/`tvalid` valid after edge t+1. Latency is 1 cycle.
- `load_req` at edge t in IDLE gives `s_set_coeffs` high after t+1, for `NBR_OF_TAPS`+1 cycles. A one-cycle gap follows.
- `s_set_coeffs` and `s_axis_fir_tvalid` are never both 1. At least one cycle with both low separates any change between them.
- A `load_req` arriving while `load_pending` is already set is absorbed; only one upload results.

## Configuration
- `FIR_FEEDER_ZERO_FILL_EN` defined:
  - When STREAM runs dry, go to FLUSH and emit `2*NBR_OF_TAPS-1` samples of `x_n`=0 with `tvalid`=1. This drains the FIR delay line.
  - A push or `load_req` during FLUSH is queued and served after FLUSH completes.
- Undefined: the FLUSH state is absent and STREAM goes directly to IDLE.

## Structure
- Package `fir_pkg`: state encoding localparams, the default widths (`X_N_SIZE`, `TAP_SIZE`, `NBR_OF_TAPS`), and the flush-length function.
- Sub-module `fir_feeder_fifo`: synchronous FIFO with count, full and empty outputs. The sequencer and coefficient bank live in the top level.

## Test plan
- Reset, then hold: `busy`=1 for 4 cycles, then 0; all outputs stay 0.
- Write `coef[0]`=3, `coef[1]`=-2, then pulse `load_req`:
  - `s_set_coeffs`=1 for 3 cycles, with `x_n` = -2, -2, 3.
  - Then one idle cycle with both strobes 0.
- Push samples 5, 7, 9 in consecutive cycles from IDLE: `x_n` = 5, 7, 9 with `tvalid`=1, starting one cycle after the first push; then `tvalid`=0.
- Push 8 samples with no pop: `s_wr_ready` drops after the 8th push; a 9th push is lost.
- Pulse `load_req` mid-stream with 4 samples queued: remaining samples resume after the CFG+GAP sequence, in order with none lost. The strobes never overlap.
- With `FIR_FEEDER_ZERO_FILL_EN` defined, stream sample 1: `x_n` = 1, 0, 0, 0 with `tvalid`=1, then IDLE.
